// File: rtl/call_stack_ctrl.sv
// Return-address stack for the decode/PC-select path: circular DEPTH-entry
// buffer with occupancy tracking, sticky error flags and a two-cycle RET sequence.
module call_stack_ctrl #(
  parameter  int DEPTH = 8,
  parameter  int AW    = 12,
  localparam int SPW   = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          init_signal,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_addr,
  input  logic          clear_err,
  output logic          stall,
  output logic          ret_valid,
  output logic [AW-1:0] ret_addr,
  output logic [AW-1:0] top_addr,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow
);

  typedef enum logic {S_IDLE, S_RETURN} state_t;

  state_t        r_state;
  logic [AW-1:0] r_mem [DEPTH];
  logic [SPW-1:0] r_sp;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_ret_addr;
  logic          r_ovf;
  logic          r_unf;

  logic [SPW-1:0] w_sp_m1;
  logic          w_empty;
  logic          w_full;
  logic          w_idle;
  logic          w_set_ovf;
  logic          w_set_unf;

  assign w_sp_m1   = r_sp - SPW'(1);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_idle    = (r_state == S_IDLE);
  assign w_set_ovf = w_idle & push & ~pop & w_full;
  assign w_set_unf = w_idle & pop & ~push & w_empty;

  // Storage: a push on a full stack lands on the oldest slot, which sp already points at
  always_ff @(posedge clock) begin
    if (w_idle) begin
      if (push && pop && !w_empty) begin
        r_mem[w_sp_m1] <= push_addr;
      end else if (push && !pop) begin
        r_mem[r_sp] <= push_addr;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (init_signal) begin
      r_state    <= S_IDLE;
      r_sp       <= '0;
      r_count    <= '0;
      r_ret_addr <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      r_ovf <= (r_ovf & ~clear_err) | w_set_ovf;
      r_unf <= (r_unf & ~clear_err) | w_set_unf;
      case (r_state)
        S_IDLE: begin
          if (pop) begin
            r_state <= S_RETURN;
            if (push) begin
              // Replace-top; on an empty stack the new address is returned directly
              r_ret_addr <= w_empty ? push_addr : r_mem[w_sp_m1];
            end else if (w_empty) begin
              r_ret_addr <= '0;
            end else begin
              r_ret_addr <= r_mem[w_sp_m1];
              r_sp       <= w_sp_m1;
              r_count    <= r_count - CW'(1);
            end
          end else if (push) begin
            r_sp <= r_sp + SPW'(1);
            if (!w_full) begin
              r_count <= r_count + CW'(1);
            end
          end
        end
        S_RETURN: begin
          // The stalled decoder re-presents its RET here, so requests are dropped
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall     = pop & w_idle;
  assign ret_valid = (r_state == S_RETURN);
  assign ret_addr  = r_ret_addr;
  assign top_addr  = w_empty ? '0 : r_mem[w_sp_m1];
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Directed bench for call_stack_ctrl: a queue-based stack model checked every
// cycle, plus hand-computed literal checks from the test plan.
module tb_call_stack_ctrl;

  localparam int DEPTH = 8;
  localparam int AW    = 12;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clock;
  logic          init_signal;
  logic          push;
  logic          pop;
  logic [AW-1:0] push_addr;
  logic          clear_err;
  logic          stall;
  logic          ret_valid;
  logic [AW-1:0] ret_addr;
  logic [AW-1:0] top_addr;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  call_stack_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock      (clock),
    .init_signal(init_signal),
    .push       (push),
    .pop        (pop),
    .push_addr  (push_addr),
    .clear_err  (clear_err),
    .stall      (stall),
    .ret_valid  (ret_valid),
    .ret_addr   (ret_addr),
    .top_addr   (top_addr),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the stack is a queue, newest entry at the back
  logic [AW-1:0] mq[$];
  bit            m_ret;
  logic [AW-1:0] m_ret_addr;
  bit            m_ovf;
  bit            m_unf;

  initial begin
    m_ret = 0; m_ret_addr = '0; m_ovf = 0; m_unf = 0;
  end

  always @(posedge clock) begin
    bit set_o, set_u;
    set_o = 0;
    set_u = 0;
    if (init_signal) begin
      mq.delete();
      m_ret = 0; m_ret_addr = '0; m_ovf = 0; m_unf = 0;
    end else begin
      if (m_ret) begin
        m_ret = 0;
      end else if (push && pop) begin
        if (mq.size() == 0) m_ret_addr = push_addr;
        else begin
          m_ret_addr = mq[mq.size()-1];
          mq[mq.size()-1] = push_addr;
        end
        m_ret = 1;
      end else if (push) begin
        if (mq.size() == DEPTH) begin
          void'(mq.pop_front());
          set_o = 1;
        end
        mq.push_back(push_addr);
      end else if (pop) begin
        if (mq.size() == 0) begin
          m_ret_addr = '0;
          set_u = 1;
        end else begin
          m_ret_addr = mq.pop_back();
        end
        m_ret = 1;
      end
      m_ovf = (m_ovf && !clear_err) || set_o;
      m_unf = (m_unf && !clear_err) || set_u;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      #1;
      chk("stall",     32'(stall),     32'(pop && !m_ret));
      chk("ret_valid", 32'(ret_valid), 32'(m_ret));
      chk("ret_addr",  32'(ret_addr),  32'(m_ret_addr));
      chk("top_addr",  32'(top_addr),  (mq.size() == 0) ? 32'd0 : 32'(mq[mq.size()-1]));
      chk("count",     32'(count),     32'(mq.size()));
      chk("empty",     32'(empty),     32'(mq.size() == 0));
      chk("full",      32'(full),      32'(mq.size() == DEPTH));
      chk("overflow",  32'(overflow),  32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
    end
  end

  task automatic cyc(input logic p, input logic q, input logic [AW-1:0] a,
                     input logic c, input logic r);
    push = p; pop = q; push_addr = a; clear_err = c; init_signal = r;
    @(negedge clock);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    push = 0; pop = 0; push_addr = '0; clear_err = 0; init_signal = 1;
    @(negedge clock);
    chk_en = 1'b1;
    #2;
    chk("lit_rst_count", 32'(count), 32'd0);
    chk("lit_rst_empty", 32'(empty), 32'd1);
    chk("lit_rst_rv",    32'(ret_valid), 32'd0);
    chk("lit_rst_top",   32'(top_addr), 32'd0);

    // Three pushes
    cyc(1, 0, 12'h010, 0, 0);
    cyc(1, 0, 12'h020, 0, 0);
    cyc(1, 0, 12'h030, 0, 0);
    #2;
    chk("lit_p3_count", 32'(count), 32'd3);
    chk("lit_p3_top",   32'(top_addr), 32'h030);
    chk("lit_p3_full",  32'(full), 32'd0);

    // Pop, held high through RETURN
    push = 0; pop = 1; push_addr = '0; clear_err = 0; init_signal = 0;
    #2;
    chk("lit_pop_stall", 32'(stall), 32'd1);
    @(negedge clock);
    #2;
    chk("lit_pop_rv",   32'(ret_valid), 32'd1);
    chk("lit_pop_addr", 32'(ret_addr), 32'h030);
    chk("lit_ret_stall", 32'(stall), 32'd0);
    idle();
    #2;
    chk("lit_pop_count", 32'(count), 32'd2);
    chk("lit_pop_top",   32'(top_addr), 32'h020);

    // Replace top with two entries
    cyc(1, 1, 12'h0AA, 0, 0);
    #2;
    chk("lit_rep_addr",  32'(ret_addr), 32'h020);
    chk("lit_rep_count", 32'(count), 32'd2);
    chk("lit_rep_top",   32'(top_addr), 32'h0AA);
    idle();

    // Replace top on an empty stack
    do_reset();
    cyc(1, 1, 12'h055, 0, 0);
    #2;
    chk("lit_byp_addr",  32'(ret_addr), 32'h055);
    chk("lit_byp_count", 32'(count), 32'd0);
    chk("lit_byp_unf",   32'(underflow), 32'd0);
    idle();

    // Overflow: nine pushes into eight slots
    do_reset();
    for (int i = 1; i <= 9; i++) cyc(1, 0, 12'(12'h100 + i), 0, 0);
    #2;
    chk("lit_ovf_flag",  32'(overflow), 32'd1);
    chk("lit_ovf_count", 32'(count), 32'd8);
    chk("lit_ovf_full",  32'(full), 32'd1);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, '0, 0, 0);
      #2;
      chk("lit_drain_addr", 32'(ret_addr), 32'(12'h109 - i));
      idle();
    end
    #2;
    chk("lit_drain_empty", 32'(empty), 32'd1);

    // Underflow, clear, and set-wins-over-clear
    cyc(0, 1, '0, 0, 0);
    #2;
    chk("lit_unf_addr", 32'(ret_addr), 32'd0);
    chk("lit_unf_flag", 32'(underflow), 32'd1);
    idle();
    cyc(0, 0, '0, 1, 0);
    #2;
    chk("lit_clr_unf", 32'(underflow), 32'd0);
    chk("lit_clr_ovf", 32'(overflow), 32'd0);
    cyc(0, 1, '0, 1, 0);
    #2;
    chk("lit_setwins_unf", 32'(underflow), 32'd1);
    idle();

    // Reset during RETURN
    cyc(1, 0, 12'h077, 0, 0);
    cyc(0, 1, '0, 0, 0);
    do_reset();
    #2;
    chk("lit_abort_rv",    32'(ret_valid), 32'd0);
    chk("lit_abort_count", 32'(count), 32'd0);
    chk("lit_abort_unf",   32'(underflow), 32'd0);
    chk("lit_abort_ovf",   32'(overflow), 32'd0);
    idle();
    idle();

    chk_en = 1'b0;
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
